// File: rtl/tt_bridge_pkg.sv
// Shared types and defaults for the serial core bridge.
// Optional feature macro: TT_BRIDGE_PC_READOUT_EN.
package tt_bridge_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int PIN_W_DEF = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EXEC = 2'd1,
    SEND = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tt_beat_shifter.sv
// Word/beat shift register with a wrapping beat counter.
// Beats enter at the top and leave at the bottom (little-endian).
module tt_beat_shifter
  import tt_bridge_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              shift,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);

  localparam int N  = WORD_W / BEAT_W;
  localparam int CW = cnt_w(N);

  logic [CW-1:0]     idx;
  logic [WORD_W-1:0] shifted;

  generate
    if (N > 1) begin : g_multi
      assign shifted = {beat_in, word[WORD_W-1:BEAT_W]};
    end else begin : g_single
      assign shifted = beat_in;
    end
  endgenerate

  assign last = (idx == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= load_word;
      idx  <= '0;
    end else if (shift) begin
      word <= shifted;
      idx  <= last ? '0 : idx + CW'(1);
    end
  end

endmodule

// File: rtl/tt_serial_core_bridge.sv
// Pad-serial to core bridge: assemble instruction, step core, stream result.
// Macro TT_BRIDGE_PC_READOUT_EN appends the captured core_addr to the output.
module tt_serial_core_bridge
  import tt_bridge_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int PIN_W = PIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIN_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIN_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  core_instr,
  output logic             core_step,
  input  logic [XLEN-1:0]  core_result,
  input  logic [XLEN-1:0]  core_addr,
  output logic             busy
);

  generate
    if ((XLEN % PIN_W) != 0 || PIN_W > XLEN) begin : g_bad_cfg
      $error("tt_serial_core_bridge: XLEN must be a multiple of PIN_W");
    end
  endgenerate

`ifdef TT_BRIDGE_PC_READOUT_EN
  localparam int OUT_W = 2 * XLEN;
  logic [OUT_W-1:0] cap_word;
  logic             unused_bits;
  assign cap_word    = {core_addr, core_result};
`else
  localparam int OUT_W = XLEN;
  logic [OUT_W-1:0] cap_word;
  logic             unused_bits;
  assign cap_word    = core_result;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             out_fire;
  logic             in_last;
  logic             out_last;
  logic [OUT_W-1:0] out_word;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == SEND);
  assign busy      = (state != LOAD);
  assign core_step = (state == EXEC) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_word[PIN_W-1:0];

`ifdef TT_BRIDGE_PC_READOUT_EN
  assign unused_bits = ^out_word;
`else
  assign unused_bits = ^{out_word, core_addr};
`endif

  tt_beat_shifter #(
    .WORD_W (XLEN),
    .BEAT_W (PIN_W)
  ) u_in (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_word ('0),
    .shift     (accept),
    .beat_in   (in_data),
    .word      (core_instr),
    .last      (in_last)
  );

  // Capture happens on the EXEC edge, so the core's values land once.
  tt_beat_shifter #(
    .WORD_W (OUT_W),
    .BEAT_W (PIN_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (state == EXEC),
    .load_word (cap_word),
    .shift     (out_fire),
    .beat_in   ('0),
    .word      (out_word),
    .last      (out_last)
  );

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == LOAD): if (accept && in_last) state_nxt = EXEC;
      (state == EXEC): state_nxt = SEND;
      (state == SEND): if (out_fire && out_last) state_nxt = LOAD;
      default:         state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

endmodule

// File: doc/tt_serial_core_bridge.md
TT_SERIAL_CORE_BRIDGE -- requirements
Module: tt_serial_core_bridge

Interface
REQ-001 Parameter XLEN, default 32: core instruction/result width in bits.
REQ-002 Parameter PIN_W, default 8: pin-side beat width; BEATS = XLEN/PIN_W.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  PIN_W  instruction beat from pads.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  bridge accepts a beat this cycle.
REQ-008 out_data  output  PIN_W  result beat to pads.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  pads consume out_data this cycle.
REQ-011 core_instr  output  XLEN  assembled instruction to core.
REQ-012 core_step  output  1  one-cycle execute enable to core.
REQ-013 core_result  input  XLEN  core ALU result, valid in the core_step cycle.
REQ-014 core_addr  input  XLEN  core PC, valid in the core_step cycle.
REQ-015 busy  output  1  high whenever state is not LOAD.

Function
REQ-016 FSM states: LOAD, EXEC, SEND; transitions LOAD->EXEC on the BEATS-th accepted beat, EXEC->SEND unconditionally, SEND->LOAD on the last accepted output beat.
REQ-017 in_ready = 1 only in LOAD; a beat is accepted iff in_valid && in_ready.
REQ-018 Beats are little-endian: accepted beat k fills core_instr bits [k*PIN_W +: PIN_W].
REQ-019 Gaps in in_valid stall LOAD without losing accepted beats; there is no timeout.
REQ-020 core_instr is registered and holds from EXEC until the first beat of the next instruction is accepted.
REQ-021 core_step = 1 exactly for the single EXEC cycle; core_result (and core_addr) are captured at the end of that cycle.
REQ-022 Latency: last input beat accepted in cycle N -> core_step in N+1 -> out_valid first high in N+2.
REQ-023 out_valid = 1 only in SEND; output beats are little-endian, starting at the captured word's bits [PIN_W-1:0].
REQ-024 While out_valid && !out_ready, out_data and beat index are held stable.
REQ-025 Beat counters wrap to 0 at each LOAD->EXEC and SEND->LOAD transition; counter width is max(1, clog2(BEATS)).
REQ-026 in_valid during EXEC/SEND is ignored and the data is not consumed.
REQ-027 XLEN not a multiple of PIN_W, or PIN_W > XLEN, is an elaboration-time error.

Reset
REQ-028 With rst=1 at a clock edge: state=LOAD, counters=0, core_instr=0, captured words=0, core_step=0, out_valid=0, out_data=0, in_ready=1, busy=0.
REQ-029 Reset mid-LOAD discards partial beats; reset mid-SEND discards unsent beats; no core_step is issued while rst=1.

Configuration
REQ-030 Macro TT_BRIDGE_PC_READOUT_EN defined: SEND emits BEATS result beats then BEATS beats of the captured core_addr (2*BEATS total).
REQ-031 Macro undefined: SEND emits only BEATS result beats; core_addr is unused.

Structure
REQ-032 Package tt_bridge_pkg holds the FSM state enum typedef and the default XLEN/PIN_W constants.
REQ-033 One sub-module tt_beat_shifter (parametrised word/beat shift register plus beat counter) is instantiated once for input assembly and once for output serialisation.

Verification
REQ-034 Beats 0x93,0x00,0x50,0x00 (addi x1,x0,5), model core_result=5 -> core_instr=0x00500093, core_step one cycle, out beats 0x05,0x00,0x00,0x00.
REQ-035 core_result=0xDEADBEEF, out_ready low 3 cycles during beat 1 -> beats 0xEF,0xBE(held 4 cycles),0xAD,0xDE.
REQ-036 rst after 2 accepted beats, then 0x13,0x00,0x00,0x00 -> core_instr=0x00000013, no core_step before the 4th new beat.
REQ-037 TT_BRIDGE_PC_READOUT_EN, core_result=0x1, core_addr=0x10 -> 8 beats 0x01,0,0,0,0x10,0,0,0 then in_ready=1.
REQ-038 PIN_W=16: beats 0x0093,0x0050 -> core_instr=0x00500093; result 0xDEADBEEF -> 0xBEEF,0xDEAD.
REQ-039 in_valid held high through EXEC/SEND -> no beat consumed; next instruction assembles from beats presented after SEND->LOAD.
